timer_event_irq: RTL

TIMER_EVENT_IRQ -- requirements
Module: timer_event_irq

---
 rtl/timer_event_irq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/timer_event_irq.sv
// Timer event interrupt block: counts timeout strobes, raises a level irq
// with ACK-driven holdoff, and exposes CTRL/STAT/COUNT/ACK/TOTAL registers.
module timer_event_irq #(
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        timeout_in,
  output logic        irq,
  output logic        toggle_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } state_t;

  localparam logic [4:0] A_CTRL  = 5'h00;
  localparam logic [4:0] A_STAT  = 5'h04;
  localparam logic [4:0] A_COUNT = 5'h08;
  localparam logic [4:0] A_ACK   = 5'h0C;
  localparam logic [4:0] A_TOTAL = 5'h10;

  localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);
  localparam logic [3:0]       H_LAST = 4'(HOLDOFF - 1);

  state_t             st_q, st_d;
  logic [3:0]         hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        total_q, total_d;
  logic               irq_en_q, irq_en_d;
  logic               tog_en_q, tog_en_d;
  logic               tog_q, tog_d;
  logic               irq_q, irq_d;

  logic       wr, ev, ack;
  logic       wr_ctrl, wr_stat, wr_tot;
  logic       sat, pnz, pnz_d, ovf_set;
  logic [4:0] off;
  logic       unused_bits;

  assign off     = addr[4:0];
  assign wr      = sel & we;
  assign ev      = timeout_in;
  assign wr_ctrl = wr && (off == A_CTRL);
  assign wr_stat = wr && (off == A_STAT);
  assign ack     = wr && (off == A_ACK);
  assign wr_tot  = wr && (off == A_TOTAL);
  assign sat     = &pend_q;
  assign pnz     = |pend_q;
  assign pnz_d   = |pend_d;

  assign unused_bits = ^{addr[31:5], wdata[31:2]};

  // Event+ACK cancel out, except at saturation where the ACK still drains.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (ev && ack) begin
      if (sat) begin
        pend_d  = pend_q - P_ONE;
        ovf_set = 1'b1;
      end
    end else if (ev) begin
      if (sat) ovf_set = 1'b1;
      else     pend_d  = pend_q + P_ONE;
    end else if (ack && pnz) begin
      pend_d = pend_q - P_ONE;
    end
  end

  always_comb begin
    ovf_d    = ovf_set | (ovf_q & ~(wr_stat & wdata[1]));
    total_d  = wr_tot ? {31'b0, ev} : total_q + {31'b0, ev};
    irq_en_d = wr_ctrl ? wdata[0] : irq_en_q;
    tog_en_d = wr_ctrl ? wdata[1] : tog_en_q;
    tog_d    = tog_q ^ (ev & tog_en_q);
  end

  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    unique case (st_q)
      IDLE: begin
        if (pnz_d) st_d = ACTIVE;
      end
      ACTIVE: begin
        if (ack) begin
          st_d   = pnz_d ? HOLD : IDLE;
          hcnt_d = '0;
        end
      end
      HOLD: begin
        if (ack) begin
          hcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
          st_d   = pnz_d ? ACTIVE : IDLE;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      default: begin
        st_d   = IDLE;
        hcnt_d = '0;
      end
    endcase
    irq_d = irq_en_d && (st_d == ACTIVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      hcnt_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      total_q  <= '0;
      irq_en_q <= 1'b0;
      tog_en_q <= 1'b0;
      tog_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      hcnt_q   <= hcnt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      total_q  <= total_d;
      irq_en_q <= irq_en_d;
      tog_en_q <= tog_en_d;
      tog_q    <= tog_d;
      irq_q    <= irq_d;
    end
  end

  assign irq        = irq_q;
  assign toggle_out = tog_q;

  always_comb begin
    rdata = '0;
    unique case (off)
      A_CTRL:  rdata = {30'b0, tog_en_q, irq_en_q};
      A_STAT:  rdata = {30'b0, ovf_q, pnz};
      A_COUNT: rdata = 32'(pend_q);
      A_TOTAL: rdata = total_q;
      default: rdata = '0;
    endcase
  end

endmodule
